// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand fetch stage: operand selects,
// the decoded-operation encoding and fixed register indices.
package operand_fetch_pkg;

  typedef enum logic {
    REG_RS1 = 1'b0,
    PC      = 1'b1
  } opA_sel_t;

  typedef enum logic {
    REG_RS2 = 1'b0,
    IMM     = 1'b1
  } opB_sel_t;

  typedef logic [5:0] instruction_type;

  localparam instruction_type NOP    = 6'd0;
  localparam logic [4:0]      REG_SP = 5'd2;
  localparam int              XLEN   = 32;
  localparam int              NREGS  = 32;

  function automatic logic [NREGS-1:0] onehot_reg(input logic [4:0] idx);
    return {{(NREGS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/operand_fetch_reg_bank.sv
// 32x32 integer register bank: two asynchronous read ports with write-through
// of the same-cycle retire write, one synchronous write port, x0 reads as zero.
module operand_fetch_reg_bank
  import operand_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] SP_INIT = 32'h0000_FFFC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) begin
        regs[k] <= (k == int'(REG_SP)) ? SP_INIT : '0;
      end
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  // Write-through lets an instruction issue in the same cycle its producer retires.
  assign rd1 = (ra1 == 5'd0)             ? '0 :
               (we && wa == ra1)         ? wd : regs[ra1];
  assign rd2 = (ra2 == 5'd0)             ? '0 :
               (we && wa == ra2)         ? wd : regs[ra2];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads operands, tracks in-flight destinations in a
// pending scoreboard, stalls decode on RAW/WAW hazards and drops stale-stream instructions.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] SP_INIT = 32'h0000_FFFC,
  parameter int              TAG_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [XLEN-1:0]     NPC_in,
  input  instruction_type     i_in,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [4:0]          rd,
  input  logic [XLEN-1:0]     imm,
  input  opA_sel_t            selA,
  input  opB_sel_t            selB,
  input  logic                writes_rd,
  input  logic [TAG_W-1:0]    stream_tag_in,
  output logic                stall,
  input  logic                ret_valid,
  input  logic [4:0]          ret_rd,
  input  logic                reg_we,
  input  logic [XLEN-1:0]     WrData,
  input  logic                jump,
  input  logic [TAG_W-1:0]    new_tag,
  output logic [XLEN-1:0]     NPC,
  output logic [XLEN-1:0]     opA,
  output logic [XLEN-1:0]     opB,
  output logic [XLEN-1:0]     opC,
  output instruction_type     i,
  output logic [4:0]          rd_out,
  output logic [TAG_W-1:0]    stream_tag_out,
  output logic                valid_out
);

  logic [XLEN-1:0]  rs1_val_p0;
  logic [XLEN-1:0]  rs2_val_p0;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] pend_eff;
  logic [TAG_W-1:0] cur_tag;
  logic [TAG_W-1:0] cur_tag_eff;
  logic             stale_p0;
  logic             hazard_p0;
  logic             issue_p0;

  logic [XLEN-1:0]  npc_p1;
  logic [XLEN-1:0]  opa_p1;
  logic [XLEN-1:0]  opb_p1;
  logic [XLEN-1:0]  opc_p1;
  instruction_type  i_p1;
  logic [4:0]       rd_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             vld_p1;

  operand_fetch_reg_bank #(
    .SP_INIT (SP_INIT)
  ) u_reg_bank (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs1),
    .ra2   (rs2),
    .rd1   (rs1_val_p0),
    .rd2   (rs2_val_p0),
    .we    (reg_we),
    .wa    (ret_rd),
    .wd    (WrData)
  );

  // ---- stage p0: hazard / stale decision on the presented instruction ----
  // Retires clear their pending bit in the same cycle so a waiting consumer can issue at once.
  assign clr_vec     = ret_valid ? onehot_reg(ret_rd) : '0;
  assign pend_eff    = pending & ~clr_vec;
  assign cur_tag_eff = jump ? new_tag : cur_tag;

  assign stale_p0  = valid_in && (stream_tag_in != cur_tag_eff);
  assign hazard_p0 = valid_in && !stale_p0 &&
                     (((selA == REG_RS1) && pend_eff[rs1]) ||
                      pend_eff[rs2] ||
                      (writes_rd && pend_eff[rd]));
  assign issue_p0  = valid_in && !stale_p0 && !hazard_p0;
  assign stall     = hazard_p0;

  assign set_vec = (issue_p0 && writes_rd && rd != 5'd0) ? onehot_reg(rd) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      cur_tag <= '0;
    end else begin
      // x0 is masked so it can never be pending; set is applied after clear so set wins.
      pending <= (pend_eff | set_vec) & ~{{(NREGS-1){1'b0}}, 1'b1};
      if (jump) begin
        cur_tag <= new_tag;
      end
    end
  end

  // ---- stage p1: output register towards execute & retire ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      i_p1   <= NOP;
      npc_p1 <= '0;
      opa_p1 <= '0;
      opb_p1 <= '0;
      opc_p1 <= '0;
      rd_p1  <= '0;
      tag_p1 <= '0;
    end else if (issue_p0) begin
      vld_p1 <= 1'b1;
      i_p1   <= i_in;
      npc_p1 <= NPC_in;
      opa_p1 <= (selA == PC)  ? NPC_in : rs1_val_p0;
      opb_p1 <= (selB == IMM) ? imm    : rs2_val_p0;
      opc_p1 <= rs2_val_p0;
      rd_p1  <= rd;
      tag_p1 <= stream_tag_in;
    end else begin
      vld_p1 <= 1'b0;
      i_p1   <= NOP;
    end
  end

  assign valid_out      = vld_p1;
  assign i              = i_p1;
  assign NPC            = npc_p1;
  assign opA            = opa_p1;
  assign opB            = opb_p1;
  assign opC            = opc_p1;
  assign rd_out         = rd_p1;
  assign stream_tag_out = tag_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed corner sequences, an operand-mux vector table
// and randomized traffic checked against a register/scoreboard reference model.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  localparam logic [31:0] SP_INIT = 32'h0000_FFFC;
  localparam int          TAG_W   = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                valid_in;
  logic [31:0]         NPC_in;
  instruction_type     i_in;
  logic [4:0]          rs1, rs2, rd;
  logic [31:0]         imm;
  opA_sel_t            selA;
  opB_sel_t            selB;
  logic                writes_rd;
  logic [TAG_W-1:0]    stream_tag_in;
  logic                stall;
  logic                ret_valid;
  logic [4:0]          ret_rd;
  logic                reg_we;
  logic [31:0]         WrData;
  logic                jump;
  logic [TAG_W-1:0]    new_tag;
  logic [31:0]         NPC, opA, opB, opC;
  instruction_type     i;
  logic [4:0]          rd_out;
  logic [TAG_W-1:0]    stream_tag_out;
  logic                valid_out;

  int total = 0;
  int bad   = 0;

  operand_fetch #(.SP_INIT(SP_INIT), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .NPC_in(NPC_in), .i_in(i_in),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .selA(selA), .selB(selB),
    .writes_rd(writes_rd), .stream_tag_in(stream_tag_in), .stall(stall),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .reg_we(reg_we), .WrData(WrData),
    .jump(jump), .new_tag(new_tag), .NPC(NPC), .opA(opA), .opB(opB), .opC(opC),
    .i(i), .rd_out(rd_out), .stream_tag_out(stream_tag_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 0; NPC_in = 0; i_in = NOP; rs1 = 0; rs2 = 0; rd = 0; imm = 0;
    selA = REG_RS1; selB = REG_RS2; writes_rd = 0; stream_tag_in = 0;
    ret_valid = 0; ret_rd = 0; reg_we = 0; WrData = 0; jump = 0; new_tag = 0;
  endtask

  task automatic instr(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic wr, input logic [TAG_W-1:0] tag);
    valid_in = 1; rs1 = a; rs2 = b; rd = d; writes_rd = wr; stream_tag_in = tag;
    selA = REG_RS1; selB = REG_RS2; i_in = 6'd5; NPC_in = 32'h40; imm = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  typedef struct {
    opA_sel_t    sa;
    opB_sel_t    sb;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] npc;
    logic [31:0] im;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ec;
  } vec_t;

  function automatic logic [31:0] mval(input logic [31:0] regs [32], input logic [4:0] r,
                                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (r == 0) return 32'd0;
    if (we && wa == r) return wd;
    return regs[r];
  endfunction

  vec_t tbl [5];

  // Reference model state
  logic [31:0]      m_regs [32];
  logic [31:0]      m_pend;
  logic [TAG_W-1:0] m_tag;
  logic [31:0]      e_npc, e_opa, e_opb, e_opc;
  instruction_type  e_i;
  logic [4:0]       e_rd;
  logic [TAG_W-1:0] e_tag;
  logic             e_vld;

  initial begin
    reset = 1;
    idle();

    // Reset state
    do_reset();
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_i", {26'd0, i}, {26'd0, NOP});
    chk("rst_npc", NPC, 32'd0);
    chk("rst_opa", opA, 32'd0);
    chk("rst_opc", opC, 32'd0);
    chk("rst_rd", {27'd0, rd_out}, 32'd0);
    chk("rst_tag", {28'd0, stream_tag_out}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // 1: sp reset value
    instr(5'd2, 5'd0, 5'd0, 1'b0, 4'd0);
    tick();
    chk("t1_valid", {31'd0, valid_out}, 32'd1);
    chk("t1_opa_sp", opA, SP_INIT);

    // 2: RAW on x5
    instr(5'd0, 5'd0, 5'd5, 1'b1, 4'd0);
    tick();
    chk("t2_rd_out", {27'd0, rd_out}, 32'd5);
    instr(5'd5, 5'd0, 5'd0, 1'b0, 4'd0);
    #1 chk("t2_stall1", {31'd0, stall}, 32'd1);
    tick();
    chk("t2_bubble", {31'd0, valid_out}, 32'd0);
    chk("t2_bubble_i", {26'd0, i}, {26'd0, NOP});
    chk("t2_stall2", {31'd0, stall}, 32'd1);
    ret_valid = 1; ret_rd = 5; reg_we = 1; WrData = 32'h1234;
    #1 chk("t2_stall_clr", {31'd0, stall}, 32'd0);
    tick();
    idle();
    chk("t2_valid", {31'd0, valid_out}, 32'd1);
    chk("t2_opa", opA, 32'h1234);

    // 3: WAW on x7
    instr(5'd0, 5'd0, 5'd7, 1'b1, 4'd0);
    tick();
    instr(5'd0, 5'd0, 5'd7, 1'b1, 4'd0);
    #1 chk("t3_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("t3_bubble", {31'd0, valid_out}, 32'd0);
    ret_valid = 1; ret_rd = 7; reg_we = 0;
    #1 chk("t3_stall_clr", {31'd0, stall}, 32'd0);
    tick();
    chk("t3_valid", {31'd0, valid_out}, 32'd1);
    chk("t3_rd_out", {27'd0, rd_out}, 32'd7);
    // set won over clear: x7 still pending, retire it
    idle();
    instr(5'd7, 5'd0, 5'd0, 1'b0, 4'd0);
    #1 chk("t3_set_wins", {31'd0, stall}, 32'd1);
    valid_in = 0;
    ret_valid = 1; ret_rd = 7;
    tick();
    idle();

    // 4: stale instruction on a jump
    jump = 1; new_tag = 3;
    tick();
    idle();
    jump = 1; new_tag = 4;
    instr(5'd0, 5'd0, 5'd10, 1'b1, 4'd3);
    #1 chk("t4_stale_nostall", {31'd0, stall}, 32'd0);
    tick();
    idle();
    chk("t4_dropped", {31'd0, valid_out}, 32'd0);
    instr(5'd10, 5'd0, 5'd0, 1'b0, 4'd4);
    #1 chk("t4_no_pending", {31'd0, stall}, 32'd0);
    tick();
    chk("t4_issue", {31'd0, valid_out}, 32'd1);
    chk("t4_tag_out", {28'd0, stream_tag_out}, 32'd4);
    instr(5'd0, 5'd0, 5'd0, 1'b0, 4'd3);
    tick();
    chk("t4_old_tag_drop", {31'd0, valid_out}, 32'd0);

    // 5: x0 stays zero and never pends
    idle();
    reg_we = 1; ret_rd = 0; WrData = 32'hFFFF_FFFF;
    instr(5'd0, 5'd0, 5'd0, 1'b1, 4'd4);
    tick();
    reg_we = 0;
    chk("t5_opa_bypass", opA, 32'd0);
    instr(5'd0, 5'd0, 5'd0, 1'b1, 4'd4);
    #1 chk("t5_x0_nostall", {31'd0, stall}, 32'd0);
    tick();
    chk("t5_opa", opA, 32'd0);
    chk("t5_opc", opC, 32'd0);
    chk("t5_valid", {31'd0, valid_out}, 32'd1);

    // 6: operand mux table (x3/x4 preloaded through the write port)
    idle();
    reg_we = 1; ret_rd = 3; WrData = 32'hAAAA_0003;
    tick();
    ret_rd = 4; WrData = 32'h5555_0004;
    tick();
    idle();
    tbl[0] = '{PC,      IMM,     5'd3, 5'd4, 32'h100, 32'hFFFF_FFF0, 32'h100,       32'hFFFF_FFF0, 32'h5555_0004};
    tbl[1] = '{REG_RS1, REG_RS2, 5'd3, 5'd4, 32'h200, 32'h7,         32'hAAAA_0003, 32'h5555_0004, 32'h5555_0004};
    tbl[2] = '{REG_RS1, IMM,     5'd2, 5'd3, 32'h300, 32'h10,        SP_INIT,       32'h10,        32'hAAAA_0003};
    tbl[3] = '{PC,      REG_RS2, 5'd0, 5'd2, 32'h400, 32'h0,         32'h400,       SP_INIT,       SP_INIT};
    tbl[4] = '{REG_RS1, REG_RS2, 5'd5, 5'd0, 32'h500, 32'h1,         32'h1234,      32'd0,         32'd0};
    for (int k = 0; k < 5; k++) begin
      instr(tbl[k].r1, tbl[k].r2, 5'd0, 1'b0, 4'd4);
      selA = tbl[k].sa; selB = tbl[k].sb; NPC_in = tbl[k].npc; imm = tbl[k].im;
      tick();
      chk($sformatf("tbl%0d_valid", k), {31'd0, valid_out}, 32'd1);
      chk($sformatf("tbl%0d_npc", k), NPC, tbl[k].npc);
      chk($sformatf("tbl%0d_opa", k), opA, tbl[k].ea);
      chk($sformatf("tbl%0d_opb", k), opB, tbl[k].eb);
      chk($sformatf("tbl%0d_opc", k), opC, tbl[k].ec);
    end
    // write-through of a same-cycle retire write
    instr(5'd0, 5'd6, 5'd0, 1'b0, 4'd4);
    reg_we = 1; ret_rd = 6; WrData = 32'hCAFE;
    tick();
    chk("bypass_opc", opC, 32'hCAFE);

    // Randomized traffic against the reference model
    do_reset();
    for (int r = 0; r < 32; r++) m_regs[r] = (r == 2) ? SP_INIT : 32'd0;
    m_pend = 0; m_tag = 0;
    e_vld = 0; e_i = NOP; e_npc = 0; e_opa = 0; e_opb = 0; e_opc = 0; e_rd = 0; e_tag = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [TAG_W-1:0] cte;
      logic [31:0]      pe, rv1, rv2;
      logic             stl, haz, iss;
      int               q[$];
      valid_in  = ($urandom_range(0, 3) != 0);
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      rd        = 5'($urandom_range(0, 7));
      writes_rd = $urandom_range(0, 1) != 0;
      selA      = opA_sel_t'($urandom_range(0, 1));
      selB      = opB_sel_t'($urandom_range(0, 1));
      NPC_in    = $urandom;
      imm       = $urandom;
      i_in      = instruction_type'($urandom_range(1, 63));
      stream_tag_in = ($urandom_range(0, 9) < 8) ? m_tag : 4'($urandom);
      q = {};
      for (int r = 1; r < 32; r++) if (m_pend[r]) q.push_back(r);
      ret_valid = (q.size() > 0) && ($urandom_range(0, 1) != 0);
      ret_rd    = ret_valid ? 5'(q[$urandom_range(0, q.size() - 1)]) : 5'($urandom_range(0, 7));
      reg_we    = ($urandom_range(0, 2) != 0) && (ret_valid || $urandom_range(0, 3) == 0);
      WrData    = $urandom;
      jump      = ($urandom_range(0, 11) == 0);
      new_tag   = 4'($urandom);

      cte = jump ? new_tag : m_tag;
      pe  = m_pend;
      if (ret_valid) pe[ret_rd] = 1'b0;
      stl = valid_in && (stream_tag_in != cte);
      haz = valid_in && !stl && ((selA == REG_RS1 && pe[rs1]) || pe[rs2] || (writes_rd && pe[rd]));
      iss = valid_in && !stl && !haz;
      rv1 = mval(m_regs, rs1, reg_we, ret_rd, WrData);
      rv2 = mval(m_regs, rs2, reg_we, ret_rd, WrData);
      #1 chk("rnd_stall", {31'd0, stall}, {31'd0, haz});

      if (iss) begin
        e_vld = 1; e_i = i_in; e_npc = NPC_in; e_rd = rd; e_tag = stream_tag_in;
        e_opa = (selA == PC) ? NPC_in : rv1;
        e_opb = (selB == IMM) ? imm : rv2;
        e_opc = rv2;
        if (writes_rd && rd != 0) pe[rd] = 1'b1;
      end else begin
        e_vld = 0; e_i = NOP;
      end
      if (reg_we && ret_rd != 0) m_regs[ret_rd] = WrData;
      m_pend = pe;
      m_tag  = cte;

      tick();
      chk("rnd_valid", {31'd0, valid_out}, {31'd0, e_vld});
      chk("rnd_i", {26'd0, i}, {26'd0, e_i});
      chk("rnd_npc", NPC, e_npc);
      chk("rnd_opa", opA, e_opa);
      chk("rnd_opb", opB, e_opb);
      chk("rnd_opc", opC, e_opc);
      chk("rnd_rd", {27'd0, rd_out}, {27'd0, e_rd});
      chk("rnd_tag", {28'd0, stream_tag_out}, {28'd0, e_tag});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
